mac_tile: RTL and testbench

MAC_TILE -- requirements
Module: mac_tile

---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_lane.sv | 25 ++
 rtl/mac_tile.sv | 138 +++++++++++++
 tb/tb_mac_tile.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC tile.
package mac_pkg;

  // Tile control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  // Signed product of a bw-bit activation (zero- or sign-extended) and a bw-bit weight.
  function automatic int prod_width(input int bw);
    return 2 * bw + 1;
  endfunction

  // Sum of col products needs log2(col) extra bits of headroom.
  function automatic int sum_width(input int bw, input int col);
    return prod_width(bw) + $clog2(col);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One lane: signed product of activation and weight, purely combinational.
module mac_lane
  import mac_pkg::*;
#(
  parameter int bw = 4
) (
  input  logic                            i_act_signed,
  input  logic [bw-1:0]                   i_a,
  input  logic [bw-1:0]                   i_b,
  output logic signed [prod_width(bw)-1:0] o_prod
);

  localparam int PW = prod_width(bw);

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;

  // Activation extends by its sign bit only when flagged signed; weights always signed.
  assign w_a_ext = {{(PW - bw){i_act_signed & i_a[bw-1]}}, i_a};
  assign w_b_ext = {{(PW - bw){i_b[bw-1]}}, i_b};

  // The true product always fits in PW bits, so truncation is exact.
  assign o_prod = w_a_ext * w_b_ext;

endmodule

// File: rtl/mac_tile.sv
// Pipelined dot-product tile: lane products -> adder tree -> stage 1 register
// -> accumulator (stage 2) -> held result with valid/ready output handshake.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready depends only on state and reset; out_valid/out/out_cnt are
// registered and stay stable until out_ready is seen with out_valid.
module mac_tile
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int cnt_bw  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  act_signed,
  input  logic [col*bw-1:0]     a,
  input  logic [col*bw-1:0]     b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [psum_bw-1:0]    out,
  output logic [cnt_bw-1:0]     out_cnt,
  output logic [1:0]            dbg_state
);

  localparam int PW = prod_width(bw);
  localparam int SW = sum_width(bw, col);

  mac_state_e r_state;
  mac_state_e w_next_state;

  logic signed [PW-1:0] w_prod [col];
  logic signed [SW-1:0] w_sum;
  logic                 w_accept;

  logic signed [SW-1:0] r_s1_sum;
  logic                 r_s1_valid;
  logic                 r_s1_last;

  logic [psum_bw-1:0]   w_s1_ext;
  logic [psum_bw-1:0]   r_acc;
  logic [cnt_bw-1:0]    r_cnt;
  logic [psum_bw-1:0]   r_out;
  logic [cnt_bw-1:0]    r_out_cnt;
  logic                 r_out_valid;

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_lane
      mac_lane #(.bw(bw)) u_lane (
        .i_act_signed (act_signed),
        .i_a          (a[gi*bw +: bw]),
        .i_b          (b[gi*bw +: bw]),
        .o_prod       (w_prod[gi])
      );
    end
  endgenerate

  // Sum all lane products at full lane-sum width (no overflow possible).
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < col; i++) begin
      w_sum = w_sum + SW'(w_prod[i]);
    end
  end

  // Ready is forced low during reset so nothing is accepted while it is held.
  assign in_ready = !reset && ((r_state == ST_IDLE) || (r_state == ST_ACC));
  assign w_accept = in_valid && in_ready;
  assign w_s1_ext = psum_bw'(r_s1_sum);

  // Next-state logic for the tile controller.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = in_last ? ST_DRAIN : ST_ACC;
      ST_ACC:   if (w_accept && in_last) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE:  if (r_out_valid && out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Stage 1: capture the lane sum of each accepted beat; sum is held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_sum   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sum  <= w_sum;
        r_s1_last <= in_last;
      end
    end
  end

  // Stage 2: accumulate, count beats, and publish the result when draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_s1_valid && !r_s1_last) r_acc <= r_acc + w_s1_ext;
      if (w_accept && (r_cnt != '1)) r_cnt <= r_cnt + cnt_bw'(1);
      if (r_state == ST_DRAIN) begin
        // Final beat is folded in directly so the accumulator can clear now.
        r_out       <= r_acc + w_s1_ext;
        r_out_cnt   <= r_cnt;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_cnt   = r_out_cnt;
  assign out_valid = r_out_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mac_tile.sv
// Bench for mac_tile (bw=4, psum_bw=16, col=8, cnt_bw=8). One-lane vectors are
// driven on lane 0 with lanes 1..7 held at zero, which adds nothing to the sum.
module tb_mac_tile;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        act_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [7:0]  out_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: running dot product and beat count of the open vector.
  int          m_acc = 0;
  int          m_cnt = 0;
  logic [15:0] m_pin_out;
  logic [7:0]  m_pin_cnt;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_cnt_q[$];

  mac_tile #(.bw(4), .psum_bw(16), .col(8), .cnt_bw(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .act_signed (act_signed),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_cnt    (out_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Model: plain integer dot product, wrapped to 16 bits, count saturating at 255.
  function automatic void model_accept(input logic [31:0] av, input logic [31:0] bv,
                                       input logic sgn, input logic last);
    for (int i = 0; i < 8; i++) begin
      int ai;
      int bi;
      ai = av[i*4 +: 4];
      bi = bv[i*4 +: 4];
      if (sgn && ai > 7) ai -= 16;
      if (bi > 7) bi -= 16;
      m_acc += ai * bi;
    end
    m_cnt++;
    if (last) begin
      m_pin_out = 16'(m_acc);
      m_pin_cnt = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
      exp_q.push_back(m_pin_out);
      exp_cnt_q.push_back(m_pin_cnt);
      m_acc = 0;
      m_cnt = 0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_beat(input logic [31:0] av, input logic [31:0] bv,
                           input logic sgn, input logic last);
    int guard;
    guard = 0;
    a = av; b = bv; act_signed = sgn; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("beat_accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(av, bv, sgn, last);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait for a result, back-pressure it for hold cycles, then retire it.
  task automatic wait_result(input int hold, output logic [15:0] r_out, output logic [7:0] r_cnt);
    int guard;
    guard = 0;
    r_out = '0;
    r_cnt = '0;
    while (!out_valid && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
    end else begin
      r_out = out;
      r_cnt = out_cnt;
      idle_cycles(hold);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    exp_cnt_q.delete();
    m_acc = 0;
    m_cnt = 0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- scoreboard compare process ----------------
  // Every cycle a result is held, it must match the oldest expected result and
  // input must be blocked; it is retired when out_ready is seen.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("sb_out", 32'(out), 32'(exp_q[0]));
        check("sb_out_cnt", 32'(out_cnt), 32'(exp_cnt_q[0]));
        check("sb_in_ready_blocked", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_cnt_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] r_o;
    logic [7:0]  r_c;
    int          av1[10];
    int          bv1[10];
    int          len;

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; act_signed = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    #3;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_out_cnt", 32'(out_cnt), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // One lane, unsigned activations, 10 beats.
    av1 = '{6, 7, 1, 3, 2, 2, 15, 4, 6, 4};
    bv1 = '{1, -7, 7, -4, -3, -2, -4, 5, -6, 4};
    for (int i = 0; i < 10; i++)
      send_beat(32'(av1[i] & 15), 32'(bv1[i] & 15), 1'b0, i == 9);
    check("model_pin_037_out", 32'(m_pin_out), 32'hFF8A);
    wait_result(1, r_o, r_c);
    check("v037_out", 32'(r_o), 32'hFF8A);
    check("v037_cnt", 32'(r_c), 32'd10);

    // Eight lanes, unsigned 15 times -8, four beats.
    for (int i = 0; i < 4; i++) send_beat(32'hFFFF_FFFF, 32'h8888_8888, 1'b0, i == 3);
    check("model_pin_038_out", 32'(m_pin_out), 32'hF100);
    wait_result(0, r_o, r_c);
    check("v038_out", 32'(r_o), 32'hF100);
    check("v038_cnt", 32'(r_c), 32'd4);

    // Signed -1 times -8 on eight lanes, single beat, with latency check.
    send_beat(32'hFFFF_FFFF, 32'h8888_8888, 1'b1, 1'b1);
    check("v039_no_valid_after_accept", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("v039_valid_second_edge", 32'(out_valid), 32'd1);
    wait_result(0, r_o, r_c);
    check("v039_out", 32'(r_o), 32'h0040);
    check("v039_cnt", 32'(r_c), 32'd1);

    // Back-pressure in DONE, then retire with a simultaneous beat offer.
    send_beat(32'd3, 32'd2, 1'b0, 1'b1);
    while (!out_valid) begin @(posedge clk); #1; end
    idle_cycles(5);
    a = 32'd5; b = 32'd1; act_signed = 1'b0; in_last = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("v040_in_ready_done", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("v040_in_ready_idle", 32'(in_ready), 32'd1);
    check("v040_valid_retired", 32'(out_valid), 32'd0);
    @(posedge clk);
    model_accept(32'd5, 32'd1, 1'b0, 1'b1);
    #1 in_valid = 1'b0;
    wait_result(0, r_o, r_c);
    check("v040_out", 32'(r_o), 32'd5);
    check("v040_cnt", 32'(r_c), 32'd1);

    // Reset while a result is pending in DONE: it must vanish.
    send_beat(32'd7, 32'd7, 1'b0, 1'b1);
    idle_cycles(3);
    check("pending_before_reset", 32'(out_valid), 32'd1);
    do_reset(2);

    // Reset after 3 of 6 beats, then a fresh 2-beat vector.
    for (int i = 0; i < 3; i++) send_beat(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    do_reset(1);
    @(negedge clk);
    check("v041_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send_beat(32'd2, 32'd3, 1'b0, 1'b0);
    send_beat(32'd4, 32'd5, 1'b0, 1'b1);
    wait_result(2, r_o, r_c);
    check("v041_out", 32'(r_o), 32'd26);
    check("v041_cnt", 32'(r_c), 32'd2);

    // 300 beats of 1*1 on one lane: count saturates, sum keeps going.
    for (int i = 0; i < 300; i++) send_beat(32'd1, 32'd1, 1'b0, i == 299);
    wait_result(0, r_o, r_c);
    check("v042_out", 32'(r_o), 32'd300);
    check("v042_cnt", 32'(r_c), 32'd255);

    // Randomized vectors with idle gaps and output back-pressure.
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        idle_cycles($urandom_range(0, 2));
        send_beat($urandom, $urandom, 1'($urandom_range(0, 1)), i == len - 1);
      end
      wait_result($urandom_range(0, 3), r_o, r_c);
    end

    idle_cycles(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
